// File: rtl/pe_ctrl_pkg.sv
// rtl/pe_ctrl_pkg.sv - shared encodings, op codes and ctrl field layout for the PE sequencer
package pe_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_ACC      = 2'd0,
      MODE_ACC_LAST = 2'd1,
      MODE_FLUSH    = 2'd2,
      MODE_RSVD     = 2'd3
   } mode_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] OP_MAC     = 3'd1;
   localparam logic [2:0] OP_MAC_ADD = 3'd2;

   localparam logic SRC_2_BUF  = 1'b0;
   localparam logic SRC_2_BIAS = 1'b1;

   // Fixed low fields of ctrl; the address and norm fields depend on the address width.
   localparam int CTRL_OP_LSB      = 0;
   localparam int CTRL_ENABLE      = 3;
   localparam int CTRL_RD_REQ      = 4;
   localparam int CTRL_WR_REQ      = 5;
   localparam int CTRL_WRITE_VALID = 6;
   localparam int CTRL_FLUSH       = 7;
   localparam int CTRL_WR_ADDR_LSB = 8;

   function automatic int ctrl_width(input int aw);
      return 10 + 2 * aw;
   endfunction

   function automatic int ctrl_rd_addr_lsb(input int aw);
      return 8 + aw;
   endfunction

   function automatic int ctrl_norm_pop(input int aw);
      return 8 + 2 * aw;
   endfunction

   function automatic int ctrl_norm_push(input int aw);
      return 9 + 2 * aw;
   endfunction

endpackage

// File: rtl/pe_ctrl_wb_pipe.sv
// rtl/pe_ctrl_wb_pipe.sv - fixed-depth {valid, addr, last} delay line with an empty flag
module pe_ctrl_wb_pipe #(
   parameter int DEPTH = 3,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push_valid,
   input  logic [AW-1:0] push_addr,
   input  logic          push_last,
   output logic          out_valid,
   output logic [AW-1:0] out_addr,
   output logic          out_last,
   output logic          empty
);

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] l_q;
   logic [AW-1:0]    a_q [DEPTH];

   always_ff @(posedge clk) begin
      if (reset) begin
         v_q <= '0;
         l_q <= '0;
         for (int i = 0; i < DEPTH; i++) a_q[i] <= '0;
      end else begin
         v_q[0] <= push_valid;
         l_q[0] <= push_last;
         a_q[0] <= push_addr;
         for (int i = 1; i < DEPTH; i++) begin
            v_q[i] <= v_q[i-1];
            l_q[i] <= l_q[i-1];
            a_q[i] <= a_q[i-1];
         end
      end
   end

   assign out_valid = v_q[DEPTH-1];
   assign out_addr  = a_q[DEPTH-1];
   assign out_last  = l_q[DEPTH-1];
   assign empty     = ~|v_q;

endmodule

// File: rtl/pe_ctrl_sequencer.sv
// rtl/pe_ctrl_sequencer.sv - per-job PE control word sequencer for accumulate and flush passes
// Optional norm FIFO push/pop generation is enabled by defining PE_CTRL_NORM_EN.
module pe_ctrl_sequencer
   import pe_ctrl_pkg::*;
#(
   parameter int PE_BUF_ADDR_WIDTH = 10,
   parameter int LEN_WIDTH         = 16,
   parameter int MACC_LAT          = 3,
   parameter int FLUSH_LAT         = 4
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic                                    start,
   input  logic [1:0]                              cfg_mode,
   input  logic                                    cfg_first,
   input  logic [PE_BUF_ADDR_WIDTH:0]              cfg_num_out,
   input  logic [LEN_WIDTH-1:0]                    cfg_macc_len,
   input  logic [LEN_WIDTH-1:0]                    cfg_center_tap,
   input  logic                                    stall,
   output logic [ctrl_width(PE_BUF_ADDR_WIDTH)-1:0] ctrl,
   output logic                                    src_2_sel,
   output logic                                    busy,
   output logic                                    done
);

   localparam int AW     = PE_BUF_ADDR_WIDTH;
   localparam int CW     = ctrl_width(AW);
   localparam int RD_LSB = ctrl_rd_addr_lsb(AW);
   localparam logic [AW:0]          ONE_N  = 1;
   localparam logic [LEN_WIDTH-1:0] ONE_L  = 1;
   localparam logic [LEN_WIDTH-1:0] ZERO_L = '0;

   state_t               state, state_nx;
   mode_t                mode_q;
   logic [AW:0]          num_q, issued_q;
   logic [LEN_WIDTH-1:0] len_q, tap_q;
   logic                 acc_mode, issue, last_tap, out_done, final_issue, zero_job, accept;
   logic                 wb_valid, wb_last, wb_empty, fl_valid, fl_last, fl_empty;
   logic [AW-1:0]        wb_addr, fl_addr;
   logic [CW-1:0]        ctrl_nx;
   logic                 unused_fl;

`ifdef PE_CTRL_NORM_EN
   logic [LEN_WIDTH-1:0] center_q;
`else
   logic                 unused_center;
   assign unused_center = ^cfg_center_tap;
`endif

   assign unused_fl   = ^{fl_addr, fl_last};
   assign acc_mode    = (mode_q == MODE_ACC) || (mode_q == MODE_ACC_LAST);
   assign issue       = (state == S_ISSUE) && !stall;
   assign last_tap    = (tap_q == len_q - ONE_L);
   // Flush completes one output per issue; accumulation only on its final tap.
   assign out_done    = issue && (!acc_mode || last_tap);
   assign final_issue = out_done && (issued_q == num_q - ONE_N);
   assign zero_job    = (cfg_num_out == '0) || (cfg_mode == MODE_RSVD) ||
                        ((cfg_mode != MODE_FLUSH) && (cfg_macc_len == ZERO_L));
   assign accept      = (state == S_IDLE) && start && !zero_job;

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = zero_job ? S_DONE : S_ISSUE;
         S_ISSUE: if (final_issue) state_nx = S_DRAIN;
         S_DRAIN: if (wb_empty && fl_empty) state_nx = S_DONE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      ctrl_nx = '0;
      if (issue) begin
         if (acc_mode) begin
            ctrl_nx[CTRL_ENABLE] = 1'b1;
            if (tap_q == ZERO_L) begin
               ctrl_nx[CTRL_OP_LSB +: 3] = OP_MAC_ADD;
               ctrl_nx[CTRL_RD_REQ]      = 1'b1;
               ctrl_nx[RD_LSB +: AW]     = issued_q[AW-1:0];
            end else begin
               ctrl_nx[CTRL_OP_LSB +: 3] = OP_MAC;
            end
`ifdef PE_CTRL_NORM_EN
            if (tap_q == center_q) ctrl_nx[ctrl_norm_push(AW)] = 1'b1;
`endif
         end else begin
            ctrl_nx[CTRL_RD_REQ]  = 1'b1;
            ctrl_nx[CTRL_FLUSH]   = 1'b1;
            ctrl_nx[RD_LSB +: AW] = issued_q[AW-1:0];
         end
      end
      if (wb_valid) begin
         if (wb_last) begin
            ctrl_nx[CTRL_WRITE_VALID] = 1'b1;
`ifdef PE_CTRL_NORM_EN
            ctrl_nx[ctrl_norm_pop(AW)] = 1'b1;
`endif
         end else begin
            ctrl_nx[CTRL_WR_REQ]                = 1'b1;
            ctrl_nx[CTRL_WR_ADDR_LSB +: AW]     = wb_addr;
         end
      end
      if (fl_valid) ctrl_nx[CTRL_WRITE_VALID] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ctrl      <= '0;
         src_2_sel <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mode_q    <= MODE_ACC;
         num_q     <= '0;
         len_q     <= '0;
         tap_q     <= '0;
         issued_q  <= '0;
`ifdef PE_CTRL_NORM_EN
         center_q  <= '0;
`endif
      end else begin
         ctrl <= ctrl_nx;
         busy <= (state_nx == S_ISSUE) || (state_nx == S_DRAIN);
         done <= (state_nx == S_DONE);
         if (accept) begin
            mode_q    <= mode_t'(cfg_mode);
            num_q     <= cfg_num_out;
            len_q     <= cfg_macc_len;
            tap_q     <= '0;
            issued_q  <= '0;
            src_2_sel <= cfg_first ? SRC_2_BIAS : SRC_2_BUF;
`ifdef PE_CTRL_NORM_EN
            center_q  <= cfg_center_tap;
`endif
         end else if (issue) begin
            if (acc_mode) tap_q <= last_tap ? ZERO_L : tap_q + ONE_L;
            if (out_done) issued_q <= issued_q + ONE_N;
         end
      end
   end

   pe_ctrl_wb_pipe #(.DEPTH(MACC_LAT), .AW(AW)) u_wb_pipe (
      .clk        (clk),
      .reset      (reset),
      .push_valid (out_done && acc_mode),
      .push_addr  (issued_q[AW-1:0]),
      .push_last  (mode_q == MODE_ACC_LAST),
      .out_valid  (wb_valid),
      .out_addr   (wb_addr),
      .out_last   (wb_last),
      .empty      (wb_empty)
   );

   pe_ctrl_wb_pipe #(.DEPTH(FLUSH_LAT), .AW(AW)) u_fl_pipe (
      .clk        (clk),
      .reset      (reset),
      .push_valid (issue && !acc_mode),
      .push_addr  (issued_q[AW-1:0]),
      .push_last  (1'b0),
      .out_valid  (fl_valid),
      .out_addr   (fl_addr),
      .out_last   (fl_last),
      .empty      (fl_empty)
   );

endmodule

// File: tb/tb_pe_ctrl_sequencer.sv
// tb/tb_pe_ctrl_sequencer.sv - directed table-driven bench for pe_ctrl_sequencer
module tb_pe_ctrl_sequencer;

   logic        clk = 1'b0;
   logic        reset, start, cfg_first, stall, src_2_sel, busy, done;
   logic [1:0]  cfg_mode;
   logic [10:0] cfg_num_out;
   logic [15:0] cfg_macc_len, cfg_center_tap;
   logic [29:0] ctrl;

   pe_ctrl_sequencer dut (
      .clk(clk), .reset(reset), .start(start), .cfg_mode(cfg_mode), .cfg_first(cfg_first),
      .cfg_num_out(cfg_num_out), .cfg_macc_len(cfg_macc_len), .cfg_center_tap(cfg_center_tap),
      .stall(stall), .ctrl(ctrl), .src_2_sel(src_2_sel), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // ctrl bit positions for a 10-bit buffer address
   localparam int B_EN = 3, B_RD = 4, B_WR = 5, B_WV = 6, B_FL = 7, B_POP = 28, B_PUSH = 29;

   int n_pass = 0, n_tot = 0;
   logic [29:0] lg_ctrl [0:1199];
   logic        lg_busy [0:1199];
   logic        lg_done [0:1199];
   logic        lg_src2 [0:1199];
   int          lg_n, lg_done_idx;

   task automatic chk(input string name, input int act, input int exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int cnt(input int b);
      int c = 0;
      for (int i = 0; i < lg_n; i++) c += int'(lg_ctrl[i][b]);
      return c;
   endfunction

   function automatic int cnt_busy();
      int c = 0;
      for (int i = 0; i < lg_n; i++) c += int'(lg_busy[i]);
      return c;
   endfunction

   function automatic int cnt_done();
      int c = 0;
      for (int i = 0; i < lg_n; i++) c += int'(lg_done[i]);
      return c;
   endfunction

   // Log index 0 is the cycle right after start is taken; index 1 carries the first issue.
   task automatic run_job(input logic [1:0] m, input logic f, input int n, input int l,
                          input int ct, input logic [63:0] sm);
      @(posedge clk); #1;
      cfg_mode = m; cfg_first = f; cfg_num_out = 11'(n);
      cfg_macc_len = 16'(l); cfg_center_tap = 16'(ct); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lg_n = 0; lg_done_idx = -1;
      for (int i = 0; i < 1200; i++) begin
         stall = (i < 64) ? sm[i] : 1'b0;
         @(negedge clk);
         lg_ctrl[i] = ctrl; lg_busy[i] = busy; lg_done[i] = done; lg_src2[i] = src_2_sel;
         lg_n = i + 1;
         if (done && lg_done_idx < 0) lg_done_idx = i;
         if (lg_done_idx >= 0 && i >= lg_done_idx + 3) break;
         @(posedge clk); #1;
      end
      stall = 1'b0;
      chk("done_seen", int'(lg_done_idx >= 0), 1);
   endtask

   typedef struct {
      logic [1:0]  mode;
      logic        first;
      int          n, l;
      logic [63:0] sm;
      int          en, rd, wr, wv, fl, done_idx;
      logic        src2;
   } vec_t;

   vec_t tbl [9];
   int   exp_op [6];
   int   nz;

   initial begin
      tbl[0] = '{2'd0, 1'b1, 2,    3, 64'h0, 6, 2, 2, 0, 0, 10, 1'b1};
      tbl[1] = '{2'd1, 1'b0, 1,    4, 64'hC, 4, 1, 0, 1, 0, 10, 1'b0};
      tbl[2] = '{2'd2, 1'b0, 4,    0, 64'h0, 0, 4, 0, 4, 4,  9, 1'b0};
      tbl[3] = '{2'd0, 1'b1, 0,    3, 64'h0, 0, 0, 0, 0, 0,  0, 1'b0};
      tbl[4] = '{2'd0, 1'b0, 5,    0, 64'h0, 0, 0, 0, 0, 0,  0, 1'b0};
      tbl[5] = '{2'd3, 1'b0, 2,    2, 64'h0, 0, 0, 0, 0, 0,  0, 1'b0};
      tbl[6] = '{2'd0, 1'b0, 3,    1, 64'h0, 3, 3, 3, 0, 0,  7, 1'b0};
      tbl[7] = '{2'd2, 1'b1, 3,    0, 64'h4, 0, 3, 0, 3, 3,  9, 1'b1};
      tbl[8] = '{2'd1, 1'b1, 2,    2, 64'h1, 4, 2, 0, 2, 0,  9, 1'b1};
      exp_op = '{2, 1, 1, 2, 1, 1};

      reset = 1'b1; start = 1'b0; stall = 1'b0; cfg_mode = '0; cfg_first = 1'b0;
      cfg_num_out = '0; cfg_macc_len = '0; cfg_center_tap = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_ctrl", int'(ctrl), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_src2", int'(src_2_sel), 0);

      for (int v = 0; v < 9; v++) begin
         run_job(tbl[v].mode, tbl[v].first, tbl[v].n, tbl[v].l, 0, tbl[v].sm);
         chk($sformatf("v%0d_enable", v), cnt(B_EN), tbl[v].en);
         chk($sformatf("v%0d_rd_req", v), cnt(B_RD), tbl[v].rd);
         chk($sformatf("v%0d_wr_req", v), cnt(B_WR), tbl[v].wr);
         chk($sformatf("v%0d_write_valid", v), cnt(B_WV), tbl[v].wv);
         chk($sformatf("v%0d_flush", v), cnt(B_FL), tbl[v].fl);
         chk($sformatf("v%0d_done_idx", v), lg_done_idx, tbl[v].done_idx);
         chk($sformatf("v%0d_done_cnt", v), cnt_done(), 1);
         chk($sformatf("v%0d_busy_cycles", v), cnt_busy(), tbl[v].done_idx);
         if (tbl[v].done_idx > 0) chk($sformatf("v%0d_src2", v), int'(lg_src2[1]), int'(tbl[v].src2));
      end

      // ACC first pass: op codes, read and write-back addresses per cycle
      run_job(2'd0, 1'b1, 2, 3, 0, 64'h0);
      for (int i = 0; i < 6; i++) chk($sformatf("acc_op%0d", i), int'(lg_ctrl[i+1][2:0]), exp_op[i]);
      chk("acc_rd0_addr", int'(lg_ctrl[1][27:18]), 0);
      chk("acc_rd1_req", int'(lg_ctrl[4][B_RD]), 1);
      chk("acc_rd1_addr", int'(lg_ctrl[4][27:18]), 1);
      chk("acc_wr0_req", int'(lg_ctrl[6][B_WR]), 1);
      chk("acc_wr0_addr", int'(lg_ctrl[6][17:8]), 0);
      chk("acc_wr1_req", int'(lg_ctrl[9][B_WR]), 1);
      chk("acc_wr1_addr", int'(lg_ctrl[9][17:8]), 1);

      // ACC_LAST with a two-cycle stall on tap 2
      run_job(2'd1, 1'b0, 1, 4, 0, 64'hC);
      chk("last_stall_en3", int'(lg_ctrl[3][B_EN]), 0);
      chk("last_en6", int'(lg_ctrl[6][B_EN]), 1);
      chk("last_wv9", int'(lg_ctrl[9][B_WV]), 1);

      // Full-buffer flush: address wrap at 1023 and write_valid latency
      run_job(2'd2, 1'b0, 1024, 0, 0, 64'h0);
      chk("full_rd_first", int'(lg_ctrl[1][27:18]), 0);
      chk("full_rd_last", int'(lg_ctrl[1024][27:18]), 1023);
      chk("full_wv4", int'(lg_ctrl[4][B_WV]), 0);
      chk("full_wv5", int'(lg_ctrl[5][B_WV]), 1);
      chk("full_wv_last", int'(lg_ctrl[1028][B_WV]), 1);
      chk("full_wv_cnt", cnt(B_WV), 1024);
      chk("full_done_idx", lg_done_idx, 1029);

      // Reset while issuing output 3 of an 8x5 job
      @(posedge clk); #1;
      cfg_mode = 2'd0; cfg_first = 1'b0; cfg_num_out = 11'd8; cfg_macc_len = 16'd5; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      @(negedge clk);
      chk("mid_enable_before_reset", int'(ctrl[B_EN]), 1);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("abort_ctrl", int'(ctrl), 0);
      chk("abort_busy", int'(busy), 0);
      nz = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (ctrl != '0 || busy || done) nz++;
      end
      chk("abort_quiet", nz, 0);
      run_job(2'd0, 1'b0, 1, 2, 0, 64'h0);
      chk("restart_rd_req", int'(lg_ctrl[1][B_RD]), 1);
      chk("restart_rd_addr", int'(lg_ctrl[1][27:18]), 0);
      chk("restart_wr_addr", int'(lg_ctrl[5][17:8]), 0);
      chk("restart_wr_req", int'(lg_ctrl[5][B_WR]), 1);
      chk("restart_done_idx", lg_done_idx, 6);

      // Norm FIFO: ACC_LAST, macc_len 9, center tap 4, three outputs
      run_job(2'd1, 1'b0, 3, 9, 4, 64'h0);
      chk("norm_wv_cnt", cnt(B_WV), 3);
`ifdef PE_CTRL_NORM_EN
      chk("norm_push_cnt", cnt(B_PUSH), 3);
      chk("norm_push_t4", int'(lg_ctrl[5][B_PUSH]), 1);
      chk("norm_push_t13", int'(lg_ctrl[14][B_PUSH]), 1);
      chk("norm_push_t22", int'(lg_ctrl[23][B_PUSH]), 1);
      chk("norm_pop_cnt", cnt(B_POP), 3);
      chk("norm_pop_wv0", int'(lg_ctrl[12][B_POP] & lg_ctrl[12][B_WV]), 1);
      chk("norm_pop_wv1", int'(lg_ctrl[21][B_POP] & lg_ctrl[21][B_WV]), 1);
      chk("norm_pop_wv2", int'(lg_ctrl[30][B_POP] & lg_ctrl[30][B_WV]), 1);
`else
      chk("norm_push_off", cnt(B_PUSH), 0);
      chk("norm_pop_off", cnt(B_POP), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule

// File: doc/pe_ctrl_sequencer.md
Name: pe_ctrl_sequencer

Overview:
- Sequencing controller for one PE (or a lock-stepped PE column).
- Per job it generates the PE control word for convolution accumulation passes and for buffer flush passes. The word drives MACC enable/op_code, PE buffer read/write requests and addresses, flush, write_valid and norm FIFO push/pop.
- Write-back timing is pipelined so that outputs issue back-to-back.
- Sits between the layer-level scheduler (job start/config) and the PE `ctrl`/`src_2_sel` inputs.

Parameters:
- PE_BUF_ADDR_WIDTH, 10, PE buffer address width; must match the PE.
- LEN_WIDTH, 16, width of the MAC count per output.
- MACC_LAT, 3, cycles from the last MAC issue to macc_out valid at the PE.
- FLUSH_LAT, 4, cycles from the flush read request to pe_buffer_read_data_d valid at the PE write_data.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  job start pulse; sampled only in IDLE
- cfg_mode  in  2  0=ACC, 1=ACC_LAST, 2=FLUSH, 3=reserved (treated as zero-length job)
- cfg_first  in  1  1: first pass, addend is bias (SRC_2_BIAS); 0: addend is buffer partial sum
- cfg_num_out  in  PE_BUF_ADDR_WIDTH+1  number of buffer entries/outputs processed
- cfg_macc_len  in  LEN_WIDTH  MAC cycles per output (ACC modes)
- cfg_center_tap  in  LEN_WIDTH  tap index pushed to the norm FIFO (optional feature only)
- stall  in  1  operands not valid this cycle; freezes issue
- ctrl  out  10+2*PE_BUF_ADDR_WIDTH  {norm_push, norm_pop, buf_rd_addr, buf_wr_addr, flush, write_valid, wr_req, rd_req, enable, op_code[2:0]}, MSB first
- src_2_sel  out  1  addend source select to the PE
- busy  out  1  job in progress
- done  out  1  one-cycle pulse at job completion

Behaviour:
- Reset: IDLE; ctrl=0, src_2_sel=0, busy=0, done=0; delay pipe cleared. Reset mid-job aborts immediately with no further ctrl activity. All outputs are registered.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE, start=1:
  - cfg_num_out=0, or an ACC mode with cfg_macc_len=0, or mode 3: go to DONE (done pulses the next cycle, no ctrl activity).
  - Otherwise latch the config, clear out_idx and tap counters, go to ISSUE; busy=1 from the next cycle.
  - start in any other state is ignored.
- ISSUE, ACC modes:
  - Each non-stalled cycle issues one MAC: enable=1.
  - tap=0: op_code=OP_MAC_ADD, rd_req=1, buf_rd_addr=out_idx.
  - tap>0: op_code=OP_MAC.
  - src_2_sel = cfg_first ? SRC_2_BIAS : SRC_2_BUF, held for the whole job.
  - When tap=macc_len-1: push {addr=out_idx, last=mode==ACC_LAST} into the MACC_LAT-deep delay pipe; tap wraps to 0; out_idx increments.
  - The next output starts the following cycle, so there are no bubbles.
- Delay pipe exit (ACC modes):
  - ACC: wr_req=1, buf_wr_addr=addr.
  - ACC_LAST: write_valid=1, wr_req=0.
- ISSUE, FLUSH mode:
  - One entry per non-stalled cycle: rd_req=1, flush=1, buf_rd_addr=out_idx, enable=0.
  - write_valid is asserted FLUSH_LAT cycles later through a separate delay pipe.
- stall=1: enable, rd_req and flush are 0 that cycle and the counters hold. Delay pipes keep shifting, so a stall never delays already-issued write-backs.
- After the last issue go to DRAIN. Wait until both pipes are empty, then go to DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- Widths: counters are unsigned; out_idx wraps modulo 2^PE_BUF_ADDR_WIDTH. cfg_num_out=2^PE_BUF_ADDR_WIDTH is legal (full buffer).
- Simultaneous events: stall on the final issue cycle delays the ISSUE→DRAIN transition by one cycle per stalled cycle.

Optional Feature:
- PE_CTRL_NORM_EN defined:
  - ACC modes: norm_push=1 on non-stalled issue cycles with tap==cfg_center_tap.
  - ACC_LAST: norm_pop=1 coincident with each write_valid.
  - FLUSH: norm_pop=0.
- Not defined: norm_push/norm_pop tied 0 and cfg_center_tap ignored.

Decomposition:
- Package pe_ctrl_pkg holds:
  - OP_MAC and OP_MAC_ADD op-code constants
  - MODE_* encodings
  - SRC_2_BIAS/SRC_2_BUF
  - ctrl field bit offsets
  - a ctrl-width function of PE_BUF_ADDR_WIDTH
- One sub-module, pe_ctrl_wb_pipe: a parameterised depth × {valid, addr, last} shift register with a "pipe empty" flag. It is instantiated twice, for write-back and flush.

Test Plan:
- ACC, first=1, num_out=2, macc_len=3, no stall → enable high 6 cycles. Op codes ADD,MAC,MAC,ADD,MAC,MAC. rd_req on cycles 0 and 3 with addr 0/1. src_2_sel=BIAS. wr_req at issue cycles 5 and 8 with addr 0/1. done 1 cycle after the last write.
- ACC_LAST, num_out=1, macc_len=4, stall high on tap 2 for 2 cycles → 4 enable pulses over 6 cycles. write_valid exactly MACC_LAT after the last enable. wr_req never asserted.
- FLUSH, num_out=4 → rd_req+flush on addr 0..3 in consecutive cycles. write_valid for 4 cycles starting FLUSH_LAT after the first read. enable=0 throughout.
- cfg_num_out=0, and separately ACC with macc_len=0 → no ctrl bits ever set; done pulses the cycle after DONE is entered; busy never set.
- Reset asserted mid-ISSUE (num_out=8, macc_len=5, out_idx=3) → next cycle ctrl=0, busy=0, no pending write-backs emerge. A new start then runs normally from addr 0.
- PE_CTRL_NORM_EN, ACC_LAST, macc_len=9, center_tap=4, num_out=3 → norm_push on taps 4, 13, 22 (counted from job start); norm_pop with each of the 3 write_valid pulses.
